// File: rtl/dma_apb_master_pkg.sv
// Shared types and defaults for the DMA APB initiator.
// Holds the FSM state encoding and the default timeout settings.
package dma_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_TOUT_BITS      = 5;

endpackage

// File: rtl/dma_apb_master_tout_cnt.sv
// Clear/enable tick counter used to abort an APB ACCESS phase that never sees pready.
// tc is high once TIMEOUT_CYCLES-1 stalled ticks have been counted.
module dma_apb_tout_cnt #(
    parameter int TOUT_BITS      = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TOUT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TOUT_BITS'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dma_apb_master.sv
// APB initiator for DMA-internal single-word accesses (descriptor fetch, status polling).
// Runs SETUP/ACCESS on pclken ticks and aborts an ACCESS phase that stalls too long.
module dma_apb_master
    import dma_apb_master_pkg::*;
#(
    parameter int ADDR_BITS      = 16,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TOUT_BITS      = DEF_TOUT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pclken,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 psel,
    output logic                 penable,
    output logic [ADDR_BITS-1:0] paddr,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    state_e                 state_q, state_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDR_BITS-1:0]   paddr_q, paddr_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   cnt_clr, cnt_en, cnt_tc;

    dma_apb_tout_cnt #(
        .TOUT_BITS      (TOUT_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Combinational so a new request can be taken in the rsp_valid cycle.
    assign req_ready = (state_q == ST_IDLE) & reset;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_write ? req_wdata : 32'h0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (pclken) begin
                    penable_d = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (pclken) begin
                    // pready on the terminal tick still counts as a normal completion.
                    if (pready || cnt_tc) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = pready ? pslverr : 1'b1;
                        rsp_timeout_d = !pready;
                        rsp_rdata_d   = (pready && !pwrite_q) ? prdata : 32'h0;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dma_apb_master.sv
// Directed and randomized checks of dma_apb_master against a transaction-level model.
// Completion edge is predicted arithmetically from the pclken period and slave wait count.
module tb_dma_apb_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pclken = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic        psel, penable, pwrite;
    logic [31:0] rsp_rdata, pwdata;
    logic [15:0] paddr;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_paddr = 16'h0;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = 32'h0;
    logic [31:0] exp_rdata = 32'h0;

    dma_apb_master #(.ADDR_BITS(16), .TIMEOUT_CYCLES(TO), .TOUT_BITS(5)) dut (
        .clk(clk), .reset(reset), .pclken(pclken),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_held();
        chk("paddr", {16'h0, paddr}, {16'h0, exp_paddr});
        chkb("pwrite", pwrite, exp_pwrite);
        chk("pwdata", pwdata, exp_pwdata);
    endtask

    task automatic noise();
        prdata  = $urandom;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
    endtask

    // Idle cycles: nothing may start, response and APB fields hold.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            req_addr  = 16'($urandom);
            pclken    = 1'($urandom);
            noise();
            step();
            chkb("idle_rsp_valid", rsp_valid, 1'b0);
            chkb("idle_busy", busy, 1'b0);
            chkb("idle_psel", psel, 1'b0);
            chkb("idle_penable", penable, 1'b0);
            chkb("idle_req_ready", req_ready, 1'b1);
            chk("idle_rsp_rdata", rsp_rdata, exp_rdata);
            chk_held();
        end
    endtask

    // One transfer: pclken every p-th edge after the accept edge, slave inserts wt
    // wait ticks in ACCESS; ends in the rsp_valid cycle with req_valid low.
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int p, input int wt, input logic serr);
        int  k;
        int  done_e;
        int  n;
        logic tout;
        tout   = (wt >= TO);
        k      = tout ? TO : wt + 1;
        done_e = p * (k + 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        pclken    = 1'($urandom);
        noise();
        chkb("req_ready_pre", req_ready, 1'b1);
        step();
        exp_paddr  = a;
        exp_pwrite = wr;
        exp_pwdata = wr ? wd : 32'h0;
        for (int e = 1; e <= done_e; e++) begin
            chkb("psel_busy", psel, 1'b1);
            chkb("penable_phase", penable, (e - 1) >= p);
            chkb("busy", busy, 1'b1);
            chkb("req_ready_busy", req_ready, 1'b0);
            chkb("rsp_valid_early", rsp_valid, 1'b0);
            chk_held();
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = $urandom;
            pclken    = (e % p == 0);
            noise();
            if (e % p == 0 && e >= 2 * p) begin
                n      = e / p - 1;
                pready = (n == wt + 1);
                if (n == wt + 1) begin
                    prdata  = rd;
                    pslverr = serr;
                end
            end
            step();
        end
        req_valid = 1'b0;
        exp_rdata = (wr || tout) ? 32'h0 : rd;
        chkb("rsp_valid", rsp_valid, 1'b1);
        chkb("rsp_err", rsp_err, tout ? 1'b1 : serr);
        chkb("rsp_timeout", rsp_timeout, tout);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chkb("psel_done", psel, 1'b0);
        chkb("penable_done", penable, 1'b0);
        chkb("busy_done", busy, 1'b0);
        chkb("req_ready_done", req_ready, 1'b1);
        chk_held();
    endtask

    initial begin
        reset = 1'b0;
        step();
        step();
        chkb("rst_psel", psel, 1'b0);
        chkb("rst_penable", penable, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_req_ready", req_ready, 1'b0);
        chkb("rst_err", rsp_err, 1'b0);
        chkb("rst_timeout", rsp_timeout, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk_held();
        reset = 1'b1;
        #1;
        chkb("req_ready_out_of_reset", req_ready, 1'b1);
        gap(2);

        // Zero-wait write and read, full-rate pclken.
        xfer(1'b1, 16'h0004, 32'hDEADBEEF, 32'h0, 1, 0, 1'b0);
        gap(1);
        xfer(1'b0, 16'h0030, 32'hFFFF_FFFF, 32'h0002_0005, 1, 0, 1'b0);
        gap(1);
        // Slow pclken: SETUP and ACCESS only move on ticks.
        xfer(1'b0, 16'h0000, 32'h0, 32'h1234_5678, 4, 2, 1'b0);
        gap(2);
        // Timeout, then pready exactly on the terminal tick.
        xfer(1'b1, 16'h0008, 32'hA5A5_5A5A, 32'h0, 1, 30, 1'b0);
        gap(1);
        xfer(1'b0, 16'h000C, 32'h0, 32'hCAFE_F00D, 1, TO - 1, 1'b0);
        gap(1);
        xfer(1'b0, 16'h0010, 32'h0, 32'h0BAD_0BAD, 3, TO, 1'b1);
        gap(1);
        // Slave error on a write, then a back-to-back accept in the rsp_valid cycle.
        xfer(1'b1, 16'h0030, 32'h0000_0001, 32'h0, 1, 0, 1'b1);
        xfer(1'b0, 16'h0034, 32'h0, 32'h5555_AAAA, 1, 1, 1'b0);
        gap(1);

        // Reset while in ACCESS drops the transfer.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040; pclken = 1'b1;
        pready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chkb("pre_rst_penable", penable, 1'b1);
        reset = 1'b0;
        pready = 1'b0;
        step();
        reset = 1'b1;
        chkb("mid_rst_psel", psel, 1'b0);
        chkb("mid_rst_penable", penable, 1'b0);
        chkb("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chkb("mid_rst_busy", busy, 1'b0);
        exp_paddr = 16'h0; exp_pwrite = 1'b0; exp_pwdata = 32'h0; exp_rdata = 32'h0;
        gap(3);

        for (int t = 0; t < 40; t++) begin
            logic wr;
            int   p;
            int   wt;
            wr = 1'($urandom);
            p  = $urandom_range(1, 4);
            wt = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 2)
                                             : $urandom_range(0, 3);
            xfer(wr, 16'($urandom), $urandom, $urandom, p, wt, 1'($urandom));
            gap($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
